// File: rtl/slib_filter_pkg.sv
// ----------------------------------------------------------------------------
// Package: slib_filter_pkg
// Shared types and helpers for the multi-input glitch filter.
//   cnt_width(size) : bits needed to hold a count in 0..size
//   filt_evt_e      : per-channel edge event (none / rise / fall)
// ----------------------------------------------------------------------------
package slib_filter_pkg;

    function automatic int cnt_width(input int size);
        return $clog2(size + 1);
    endfunction

    typedef enum logic [1:0] {
        EV_NONE = 2'd0,
        EV_RISE = 2'd1,
        EV_FALL = 2'd2
    } filt_evt_e;

endpackage

// File: rtl/slib_filter_channel.sv
// ----------------------------------------------------------------------------
// Module: slib_filter_channel
// One filter channel: optional 2-flop synchronizer, saturating up/down
// counter advanced on ce_i, hysteresis level and registered edge event.
//
// Build option: define SLIB_MULTI_INPUT_FILTER_SYNC_EN to insert a 2-flop
// synchronizer on d_i (adds two cycles of latency).
//
// Ports:
//   clk_i    in   clock
//   rst_i    in   asynchronous reset, active-high
//   ce_i     in   sample enable for the counter
//   d_i      in   raw input bit
//   q_o      out  filtered level (registered)
//   evt_d_o  out  next-cycle edge event (feeds the sticky change flag)
//   evt_o    out  registered edge event, valid alongside the new q_o
// ----------------------------------------------------------------------------
module slib_filter_channel
    import slib_filter_pkg::*;
#(
    parameter int SIZE   = 4,
    parameter int HI_THR = 4,
    parameter int LO_THR = 0
) (
    input  logic      clk_i,
    input  logic      rst_i,
    input  logic      ce_i,
    input  logic      d_i,
    output logic      q_o,
    output filt_evt_e evt_d_o,
    output filt_evt_e evt_o
);

    localparam int CW = cnt_width(SIZE);
    localparam logic [CW-1:0] SIZE_C = CW'(SIZE);
    localparam logic [CW-1:0] HI_C   = CW'(HI_THR);
    localparam logic [CW-1:0] LO_C   = CW'(LO_THR);

    logic          d_s;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          q_q, q_d;
    filt_evt_e     evt_q, evt_d;

`ifdef SLIB_MULTI_INPUT_FILTER_SYNC_EN
    logic [1:0] sync_q;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[0], d_i};
        end
    end

    assign d_s = sync_q[1];
`else
    // Caller guarantees d_i is already synchronous to clk_i.
    assign d_s = d_i;
`endif

    // Saturating counter: never wraps past 0 or SIZE.
    always_comb begin
        // NOTE: default assignment first so every path drives cnt_d; a missing
        // else branch would otherwise infer a latch.
        cnt_d = cnt_q;
        if (ce_i) begin
            if (d_s && (cnt_q != SIZE_C)) begin
                cnt_d = cnt_q + CW'(1);
            end else if (!d_s && (cnt_q != '0)) begin
                cnt_d = cnt_q - CW'(1);
            end
        end
    end

    // Level decision uses the pre-update count every clock, independent of
    // ce_i; counts strictly between the thresholds hold the current level.
    always_comb begin
        q_d = q_q;
        if (cnt_q >= HI_C) begin
            q_d = 1'b1;
        end else if (cnt_q <= LO_C) begin
            q_d = 1'b0;
        end
    end

    always_comb begin
        evt_d = EV_NONE;
        if (q_d && !q_q) begin
            evt_d = EV_RISE;
        end else if (!q_d && q_q) begin
            evt_d = EV_FALL;
        end
    end

    // NOTE: the async reset clears every flop here; since q_q returns to 0 with
    // the count at 0, neither reset nor its release can produce an edge event.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            cnt_q <= '0;
            q_q   <= 1'b0;
            evt_q <= EV_NONE;
        end else begin
            // NOTE: non-blocking assignments so all state updates see the
            // values from before this edge.
            cnt_q <= cnt_d;
            q_q   <= q_d;
            evt_q <= evt_d;
        end
    end

    assign q_o     = q_q;
    assign evt_d_o = evt_d;
    assign evt_o   = evt_q;

endmodule

// File: rtl/slib_multi_input_filter.sv
// ----------------------------------------------------------------------------
// Module: slib_multi_input_filter
// WIDTH-channel glitch filter with hysteresis for slow asynchronous pins.
// Each channel reports 1-cycle rise/fall pulses and a sticky change flag
// that software clears; any_o is the registered OR of all change flags.
//
// Build option: SLIB_MULTI_INPUT_FILTER_SYNC_EN adds a 2-flop synchronizer
// per input (see slib_filter_channel).
//
// Ports:
//   clk_i   in   clock
//   rst_i   in   asynchronous reset, active-high
//   ce_i    in   sample enable; counters move only when 1
//   d_i     in   [WIDTH] raw inputs
//   clr_i   in   [WIDTH] per-channel clear of chg_o
//   q_o     out  [WIDTH] filtered levels
//   rise_o  out  [WIDTH] 1-cycle pulse when q_o[i] goes 0->1
//   fall_o  out  [WIDTH] 1-cycle pulse when q_o[i] goes 1->0
//   chg_o   out  [WIDTH] sticky change flags
//   any_o   out  OR of chg_o, registered alongside it
// ----------------------------------------------------------------------------
module slib_multi_input_filter
    import slib_filter_pkg::*;
#(
    parameter int WIDTH  = 1,
    parameter int SIZE   = 4,
    parameter int HI_THR = 4,
    parameter int LO_THR = 0
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             ce_i,
    input  logic [WIDTH-1:0] d_i,
    input  logic [WIDTH-1:0] clr_i,
    output logic [WIDTH-1:0] q_o,
    output logic [WIDTH-1:0] rise_o,
    output logic [WIDTH-1:0] fall_o,
    output logic [WIDTH-1:0] chg_o,
    output logic             any_o
);

    if (!((LO_THR >= 0) && (LO_THR < HI_THR) && (HI_THR <= SIZE))) begin : g_bad_param
        $error("slib_multi_input_filter: need 0 <= LO_THR < HI_THR <= SIZE");
    end

    filt_evt_e        evt_d [WIDTH];
    filt_evt_e        evt_q [WIDTH];
    logic [WIDTH-1:0] edge_d;
    logic [WIDTH-1:0] chg_q, chg_d;
    logic             any_q;

    for (genvar i = 0; i < WIDTH; i++) begin : g_ch
        slib_filter_channel #(
            .SIZE   (SIZE),
            .HI_THR (HI_THR),
            .LO_THR (LO_THR)
        ) u_ch (
            .clk_i   (clk_i),
            .rst_i   (rst_i),
            .ce_i    (ce_i),
            .d_i     (d_i[i]),
            .q_o     (q_o[i]),
            .evt_d_o (evt_d[i]),
            .evt_o   (evt_q[i])
        );

        assign rise_o[i] = (evt_q[i] == EV_RISE);
        assign fall_o[i] = (evt_q[i] == EV_FALL);
        assign edge_d[i] = (evt_d[i] != EV_NONE);
    end

    // A transition landing in the same cycle as a clear keeps the flag set,
    // so no event is ever lost to a concurrent software clear.
    assign chg_d = (chg_q & ~clr_i) | edge_d;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            chg_q <= '0;
            any_q <= 1'b0;
        end else begin
            chg_q <= chg_d;
            any_q <= |chg_d;
        end
    end

    assign chg_o = chg_q;
    assign any_o = any_q;

endmodule

// File: tb/tb_slib_multi_input_filter.sv
// ----------------------------------------------------------------------------
// Bench for slib_multi_input_filter. Two instances share clock, reset and
// sample enable: u_a (4 channels, default thresholds) and u_b (2 channels,
// SIZE=8, HI_THR=6, LO_THR=2). A per-channel behavioural model tracks the
// expected outputs; directed steps add fixed-value checks at key cycles.
// ----------------------------------------------------------------------------
module tb_slib_multi_input_filter;

`ifdef SLIB_MULTI_INPUT_FILTER_SYNC_EN
    localparam int LAT = 2;
`else
    localparam int LAT = 0;
`endif

    typedef struct {
        int cnt;
        bit q;
        bit rise;
        bit fall;
        bit chg;
        bit s1;
        bit s2;
    } ch_t;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       ce  = 1'b0;
    logic [3:0] da  = '0, clra = '0;
    logic [1:0] db  = '0, clrb = '0;
    logic [3:0] qa, risea, falla, chga;
    logic [1:0] qb, riseb, fallb, chgb;
    logic       anya, anyb;

    int n_checks = 0;
    int n_err    = 0;

    ch_t ma [4];
    ch_t mb [2];

    always #5 clk = ~clk;

    slib_multi_input_filter #(.WIDTH(4)) u_a (
        .clk_i (clk), .rst_i (rst), .ce_i (ce), .d_i (da), .clr_i (clra),
        .q_o (qa), .rise_o (risea), .fall_o (falla), .chg_o (chga), .any_o (anya)
    );

    slib_multi_input_filter #(.WIDTH(2), .SIZE(8), .HI_THR(6), .LO_THR(2)) u_b (
        .clk_i (clk), .rst_i (rst), .ce_i (ce), .d_i (db), .clr_i (clrb),
        .q_o (qb), .rise_o (riseb), .fall_o (fallb), .chg_o (chgb), .any_o (anyb)
    );

    // One channel, one clock edge, straight from the behavioural rules.
    function automatic ch_t ch_next(ch_t c, bit d, bit en, bit clr, int size, int hi, int lo);
        ch_t n;
        bit  dv;
        n = c;
`ifdef SLIB_MULTI_INPUT_FILTER_SYNC_EN
        dv   = c.s2;
        n.s1 = d;
        n.s2 = c.s1;
`else
        dv = d;
`endif
        if (en) begin
            if (dv) n.cnt = (c.cnt < size) ? c.cnt + 1 : size;
            else    n.cnt = (c.cnt > 0)    ? c.cnt - 1 : 0;
        end
        if (c.cnt >= hi)      n.q = 1'b1;
        else if (c.cnt <= lo) n.q = 1'b0;
        n.rise = n.q && !c.q;
        n.fall = !n.q && c.q;
        n.chg  = (c.chg && !clr) || (n.q != c.q);
        return n;
    endfunction

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < 4; i++) ma[i] <= '{default: 0};
            for (int i = 0; i < 2; i++) mb[i] <= '{default: 0};
        end else begin
            for (int i = 0; i < 4; i++) ma[i] <= ch_next(ma[i], da[i], ce, clra[i], 4, 4, 0);
            for (int i = 0; i < 2; i++) mb[i] <= ch_next(mb[i], db[i], ce, clrb[i], 8, 6, 2);
        end
    end

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_model();
        logic [3:0] eq, er, ef, ec;
        logic [1:0] bq, br, bf, bc;
        for (int i = 0; i < 4; i++) begin
            eq[i] = ma[i].q; er[i] = ma[i].rise; ef[i] = ma[i].fall; ec[i] = ma[i].chg;
        end
        for (int i = 0; i < 2; i++) begin
            bq[i] = mb[i].q; br[i] = mb[i].rise; bf[i] = mb[i].fall; bc[i] = mb[i].chg;
        end
        check("a_q",    8'(qa),    8'(eq));
        check("a_rise", 8'(risea), 8'(er));
        check("a_fall", 8'(falla), 8'(ef));
        check("a_chg",  8'(chga),  8'(ec));
        check("a_any",  8'(anya),  8'(|ec));
        check("b_q",    8'(qb),    8'(bq));
        check("b_rise", 8'(riseb), 8'(br));
        check("b_fall", 8'(fallb), 8'(bf));
        check("b_chg",  8'(chgb),  8'(bc));
        check("b_any",  8'(anyb),  8'(|bc));
    endtask

    // Wait past the next active edge, then compare against the model.
    task automatic step();
        @(negedge clk);
        check_model();
    endtask

    initial begin
        bit saw;

        // Reset state.
        repeat (2) @(negedge clk);
        check("rst_q",   8'({qa, qb}),       8'h00);
        check("rst_evt", 8'({risea, falla}), 8'h00);
        check("rst_chg", 8'({chga, chgb}),   8'h00);
        check("rst_any", 8'({anya, anyb}),   8'h00);

        // Test 1: steady high input, Q rises on edge HI_THR+1 (+sync latency).
        rst = 1'b0;
        ce  = 1'b1;
        da  = 4'b0001;
        for (int e = 1; e <= 8; e++) begin
            step();
            if (e == 4 + LAT) check("t1_q_before", 8'(qa[0]), 8'h0);
            if (e == 5 + LAT) begin
                check("t1_q_rise",   8'(qa[0]),    8'h1);
                check("t1_rise_hi",  8'(risea[0]), 8'h1);
            end
            if (e == 6 + LAT) begin
                check("t1_rise_lo",  8'(risea[0]), 8'h0);
                check("t1_chg_held", 8'(chga[0]),  8'h1);
            end
        end

        // Test 2: hysteresis on u_b, saturate at 8 then fall through the band.
        db = 2'b01;
        repeat (14) step();
        check("t2_q_sat", 8'(qb[0]), 8'h1);
        db = 2'b00;
        for (int e = 1; e <= 9; e++) begin
            step();
            if (e == 6 + LAT) check("t2_q_band", 8'(qb[0]), 8'h1);
            if (e == 7 + LAT) begin
                check("t2_q_fall",  8'(qb[0]),    8'h0);
                check("t2_fall_hi", 8'(fallb[0]), 8'h1);
            end
            if (e == 8 + LAT) check("t2_fall_lo", 8'(fallb[0]), 8'h0);
        end

        // Test 3: 3-tick glitch on u_a channel 1 never reaches Q.
        saw = 1'b0;
        da  = 4'b0011;
        repeat (3) step();
        da = 4'b0001;
        for (int e = 0; e < 8; e++) begin
            step();
            if (qa[1] || risea[1]) saw = 1'b1;
        end
        check("t3_glitch_seen", 8'(saw),     8'h0);
        check("t3_chg",         8'(chga[1]), 8'h0);

        // Test 4: sparse CE, two channels rise together.
        da = 4'b0000;
        repeat (8) step();
        clra = 4'hF; clrb = 2'b11;
        step();
        clra = 4'h0; clrb = 2'b00;
        check("t4_any_cleared", 8'({anya, anyb}), 8'h00);
        saw = 1'b0;
        da  = 4'b1010;
        for (int k = 0; k < 24; k++) begin
            ce = (k % 3 == 0);
            step();
            if (risea === 4'b1010) saw = 1'b1;
        end
        ce = 1'b1;
        check("t4_rise_together", 8'(saw),  8'h1);
        check("t4_q",             8'(qa),   8'ha);
        check("t4_any",           8'(anya), 8'h1);

        // Test 5: clear coinciding with a fall keeps CHG; a later clear drops it.
        clra = 4'hF;
        step();
        clra = 4'h0;
        check("t5_chg_clr", 8'(chga), 8'h0);
        da = 4'b1000;
        for (int e = 1; e <= 7; e++) begin
            clra = ((e == 5 + LAT) || (e == 6 + LAT)) ? 4'b0010 : 4'b0000;
            step();
            if (e == 5 + LAT) begin
                check("t5_fall",     8'(falla[1]), 8'h1);
                check("t5_chg_wins", 8'(chga[1]),  8'h1);
            end
            if (e == 6 + LAT) begin
                check("t5_chg_cleared", 8'(chga[1]), 8'h0);
                check("t5_any_zero",    8'(anya),    8'h0);
            end
        end
        clra = 4'h0;

        // Randomized traffic against the model.
        for (int k = 0; k < 400; k++) begin
            ce = ($urandom_range(0, 3) != 0);
            for (int i = 0; i < 4; i++) begin
                if ($urandom_range(0, 5) == 0) da[i] = ~da[i];
                clra[i] = ($urandom_range(0, 9) == 0);
            end
            for (int i = 0; i < 2; i++) begin
                if ($urandom_range(0, 5) == 0) db[i] = ~db[i];
                clrb[i] = ($urandom_range(0, 9) == 0);
            end
            step();
        end

        // Test 6: reset mid-count with Q=1, count=3.
        ce = 1'b1; clra = '0; clrb = '0;
        da = 4'b0001; db = 2'b00;
        repeat (12) step();
        da = 4'b0000;
        repeat (LAT + 1) step();
        check("t6_q_before_rst", 8'(qa[0]), 8'h1);
        rst = 1'b1;
        #1;
        check("t6_rst_q",   8'({qa, qb}),                   8'h00);
        check("t6_rst_evt", 8'({risea, falla, riseb, fallb}), 8'h00);
        check("t6_rst_chg", 8'({chga, chgb, anya, anyb}),   8'h00);
        check_model();
        @(negedge clk);
        rst = 1'b0;
        for (int e = 0; e < 8; e++) begin
            step();
            check("t6_no_pulse", 8'({risea, falla, riseb, fallb}), 8'h00);
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
